// File: rtl/block_interleaver.sv
// rtl/block_interleaver.sv - ROWS x COLS block (de)interleaver, ping-pong banks, flush; INTLV_FLUSH_PAD_EN adds zero-padded final frame
module block_interleaver #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int W    = 1,
  parameter int MODE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         flush,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_sof,
  output logic         busy
);

  localparam int N  = ROWS * COLS;
  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  typedef enum logic [1:0] {S_FILL, S_STREAM, S_FLUSH} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] wcnt, wcnt_nx;
  logic [AW-1:0] rcnt, rcnt_nx;
  logic          wb, wb_nx;
  logic          pad_ph, pad_ph_nx;

  logic          wr_en;
  logic          rd_en;
  logic          rd_bank;
  logic          rd_zero;
  logic [AW-1:0] rd_addr;

  logic [W-1:0]  mem0 [N];
  logic [W-1:0]  mem1 [N];

  // Read index to storage address; data is always written row-major.
  function automatic logic [AW-1:0] perm(input logic [AW-1:0] r);
    int ri;
    int a;
    ri = int'(r);
    if (MODE == 0) a = (ri % ROWS) * COLS + ri / ROWS;
    else           a = (ri % COLS) * ROWS + ri / COLS;
    return a[AW-1:0];
  endfunction

  assign rd_addr = perm(rcnt);
  assign busy    = (state == S_FLUSH);

  // State, counters and bank select.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_FILL;
      wcnt   <= '0;
      rcnt   <= '0;
      wb     <= 1'b0;
      pad_ph <= 1'b0;
    end else begin
      state  <= state_nx;
      wcnt   <= wcnt_nx;
      rcnt   <= rcnt_nx;
      wb     <= wb_nx;
      pad_ph <= pad_ph_nx;
    end
  end

  // Next state: accept the input symbol first, then act on flush.
  always_comb begin
    state_nx  = state;
    wcnt_nx   = wcnt;
    rcnt_nx   = rcnt;
    wb_nx     = wb;
    pad_ph_nx = pad_ph;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    rd_bank   = ~wb;
    rd_zero   = 1'b0;
    case (state)
      S_FILL: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (wcnt == LAST) begin
            wcnt_nx  = '0;
            wb_nx    = ~wb;
            state_nx = S_STREAM;
          end else begin
            wcnt_nx = wcnt + AW'(1);
          end
        end
        if (flush) begin
          if (state_nx == S_STREAM) begin
            // The symbol just completed a frame: drain it whole.
            state_nx  = S_FLUSH;
            pad_ph_nx = 1'b0;
          end else if (wcnt_nx != '0) begin
`ifdef INTLV_FLUSH_PAD_EN
            state_nx  = S_FLUSH;
            pad_ph_nx = 1'b1;
            rcnt_nx   = '0;
`else
            // Partial frame with nothing to pad it into: discard.
            wcnt_nx = '0;
            wb_nx   = 1'b0;
`endif
          end
        end
      end
      S_STREAM: begin
        if (in_valid) begin
          wr_en = 1'b1;
          rd_en = 1'b1;
          if (wcnt == LAST) begin
            wcnt_nx = '0;
            rcnt_nx = '0;
            wb_nx   = ~wb;
          end else begin
            wcnt_nx = wcnt + AW'(1);
            rcnt_nx = rcnt + AW'(1);
          end
        end
        if (flush) begin
          state_nx  = S_FLUSH;
          pad_ph_nx = 1'b0;
        end
      end
      S_FLUSH: begin
        rd_en = 1'b1;
        if (pad_ph) begin
          // Partial write frame: unwritten addresses read as zero.
          rd_bank = wb;
          rd_zero = (rd_addr >= wcnt);
        end
        if (rcnt == LAST) begin
          rcnt_nx = '0;
`ifdef INTLV_FLUSH_PAD_EN
          if (!pad_ph && wcnt != '0) begin
            pad_ph_nx = 1'b1;
          end else begin
            state_nx  = S_FILL;
            wcnt_nx   = '0;
            wb_nx     = 1'b0;
            pad_ph_nx = 1'b0;
          end
`else
          state_nx  = S_FILL;
          wcnt_nx   = '0;
          wb_nx     = 1'b0;
          pad_ph_nx = 1'b0;
`endif
        end else begin
          rcnt_nx = rcnt + AW'(1);
        end
      end
      default: begin
        state_nx = S_FILL;
      end
    endcase
  end

  // Symbol storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wb) mem1[wcnt] <= in_data;
      else    mem0[wcnt] <= in_data;
    end
  end

  // Registered output: one cycle after the read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
    end else begin
      out_valid <= rd_en;
      out_sof   <= rd_en && (rcnt == '0);
      if (rd_en) begin
        if (rd_zero)      out_data <= '0;
        else if (rd_bank) out_data <= mem1[rd_addr];
        else              out_data <= mem0[rd_addr];
      end
    end
  end

endmodule
